product_accumulator: RTL and testbench

//  Downstream consumer of the 16x16 unsigned array multiplier. Takes its 32-bit product
//  one term per beat over a valid/ready handshake and sums terms into an ACC_W-bit

---
 rtl/product_accumulator.sv | 156 +++++++++++++++
 tb/tb_product_accumulator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: sums unsigned multiplier products one term per accepted beat.
// The beat flagged last publishes {sum, term count, overflow} on a registered
// valid/ready result port and restarts the accumulator on the same edge, so
// back-to-back sums run with no bubble.
module product_accumulator #(
    parameter int PROD_W   = 32,
    parameter int ACC_W    = 40,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [15:0]       out_count,
    output logic              out_ovf
);

    localparam int EXT_W = ACC_W - PROD_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_n;

    logic [ACC_W-1:0]   r_acc;
    logic [15:0]        r_cnt;
    logic               r_ovf;

    logic [ACC_W-1:0]   r_out_sum;
    logic [15:0]        r_out_count;
    logic               r_out_ovf;

    logic               w_out_valid;
    logic               w_in_ready;
    logic               w_fire;
    logic               w_retire;

    logic [ACC_W-1:0]   w_acc_base;
    logic [15:0]        w_cnt_base;
    logic               w_ovf_base;
    logic [ACC_W:0]     w_sum_wide;
    logic               w_carry;
    logic [ACC_W-1:0]   w_acc_n;
    logic [15:0]        w_cnt_n;
    logic               w_ovf_n;

    // A result is pending exactly while the FSM sits in HOLD.
    assign w_out_valid = (r_state == HOLD);
    assign w_in_ready  = !w_out_valid || out_ready;
    assign w_fire      = in_valid && w_in_ready;
    assign w_retire    = w_out_valid && out_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

    // Next accumulator values for an accepted beat; clear in the same cycle makes
    // the beat the first term of a fresh sum.
    always_comb begin
        w_acc_base = clear ? '0 : r_acc;
        w_cnt_base = clear ? '0 : r_cnt;
        w_ovf_base = clear ? 1'b0 : r_ovf;
        w_sum_wide = {1'b0, w_acc_base} + {{EXT_W{1'b0}}, in_product};
        w_carry    = w_sum_wide[ACC_W];
        if (w_carry && SATURATE)
            w_acc_n = '1;
        else
            w_acc_n = w_sum_wide[ACC_W-1:0];
        w_ovf_n    = w_ovf_base || w_carry;
        w_cnt_n    = (w_cnt_base == 16'hFFFF) ? 16'hFFFF : w_cnt_base + 16'd1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_n;
    end

    // FSM next state: HOLD tracks a pending result, ACCUM a non-empty partial sum.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE: begin
                if (w_fire)
                    w_state_n = in_last ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (w_fire)
                    w_state_n = in_last ? HOLD : ACCUM;
                else if (clear)
                    w_state_n = IDLE;
            end
            HOLD: begin
                if (w_retire) begin
                    if (w_fire)
                        w_state_n = in_last ? HOLD : ACCUM;
                    else
                        w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // Partial-sum registers: add on a beat, restart on last beat or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_fire) begin
            if (in_last) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_acc_n;
                r_cnt <= w_cnt_n;
                r_ovf <= w_ovf_n;
            end
        end else if (clear) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end
    end

    // Result registers load only on an accepted last beat, so they stay stable
    // under backpressure (a last beat cannot be accepted while stalled).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_fire && in_last) begin
            r_out_sum   <= w_acc_n;
            r_out_count <= w_cnt_n;
            r_out_ovf   <= w_ovf_n;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances (saturating and wrapping) share
// one stimulus stream; a bench-side model predicts each result into a queue.
module tb_product_accumulator;

    typedef struct {
        logic [39:0] sum;
        logic [15:0] cnt;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_product = '0;
    logic        in_last = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, out_ovf0;
    logic [39:0] out_sum0;
    logic [15:0] out_count0;
    logic        in_ready1, out_valid1, out_ovf1;
    logic [39:0] out_sum1;
    logic [15:0] out_count1;

    int checks = 0;
    int failures = 0;

    // model state; index 0 = saturating DUT, 1 = wrapping DUT
    logic [63:0] m_acc [2];
    int          m_cnt [2];
    bit          m_ovf [2];
    bit          m_pend;
    res_t        q0 [$];
    res_t        q1 [$];

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(32), .ACC_W(40), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_product(in_product), .in_last(in_last), .clear(clear),
        .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
        .out_count(out_count0), .out_ovf(out_ovf0)
    );

    product_accumulator #(.PROD_W(32), .ACC_W(40), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_product(in_product), .in_last(in_last), .clear(clear),
        .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
        .out_count(out_count1), .out_ovf(out_ovf1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
            m_ovf[i] = 0;
        end
        m_pend = 0;
        q0.delete();
        q1.delete();
    endtask

    // Apply one cycle of inputs (called at posedge+1), check, advance model.
    task automatic step(input bit v, input logic [31:0] p, input bit last,
                        input bit clr, input bit ordy);
        bit   exp_rdy, fire, retire;
        res_t r;
        logic [63:0] s;
        in_valid = v; in_product = p; in_last = last; clear = clr; out_ready = ordy;
        #1;
        exp_rdy = !m_pend || ordy;
        fire    = v && exp_rdy;
        retire  = m_pend && ordy;
        chk("in_ready_sat", in_ready0, exp_rdy);
        chk("in_ready_wrap", in_ready1, exp_rdy);
        chk("out_valid_sat", out_valid0, m_pend);
        chk("out_valid_wrap", out_valid1, m_pend);
        if (m_pend) begin
            if (q0.size() == 0 || q1.size() == 0) begin
                chk("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                chk("sum_sat", out_sum0, q0[0].sum);
                chk("count_sat", out_count0, q0[0].cnt);
                chk("ovf_sat", out_ovf0, q0[0].ovf);
                chk("sum_wrap", out_sum1, q1[0].sum);
                chk("count_wrap", out_count1, q1[0].cnt);
                chk("ovf_wrap", out_ovf1, q1[0].ovf);
                if (retire) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
            end
            if (fire) begin
                s = m_acc[i] + {32'd0, p};
                if (s >= 64'h100_0000_0000) begin
                    m_ovf[i] = 1;
                    s = (i == 0) ? 64'hFF_FFFF_FFFF : (s & 64'hFF_FFFF_FFFF);
                end
                m_acc[i] = s;
                if (m_cnt[i] < 65535) m_cnt[i]++;
                if (last) begin
                    r.sum = s[39:0];
                    r.cnt = m_cnt[i][15:0];
                    r.ovf = m_ovf[i];
                    if (i == 0) q0.push_back(r); else q1.push_back(r);
                    m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
                end
            end
        end
        if (fire && last) m_pend = 1;
        else if (retire) m_pend = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; clear = 0; in_last = 0;
        rst_n = 0;
        #1;
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_in_ready", in_ready0, 1'b1);
        chk("rst_out_sum", out_sum1, 40'd0);
        chk("rst_out_count", out_count0, 16'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // 1: reset mid-sum and mid-HOLD drops state
        step(1, 32'd100, 0, 0, 1);
        step(1, 32'd200, 0, 0, 1);
        do_reset();
        step(1, 32'd55, 1, 0, 0);
        do_reset();
        chk("rst_hold_valid", out_valid0, 1'b0);

        // 2: three-term sum
        step(1, 32'h0001_0000, 0, 0, 1);
        step(1, 32'hFFFE_0001, 0, 0, 1);
        step(1, 32'h0000_0003, 1, 0, 1);
        chk("t2_sum", out_sum0, 40'h00_FFFF_0004);
        chk("t2_count", out_count0, 16'd3);
        chk("t2_ovf", out_ovf0, 1'b0);

        // 3: backpressure for 5 cycles, then retire with a single-term last beat
        for (int i = 0; i < 5; i++) step(1, 32'd99, 1, 0, 0);
        chk("t3_stall_ready", in_ready0, 1'b0);
        step(1, 32'd7, 1, 0, 1);
        chk("t3_sum", out_sum0, 40'd7);
        chk("t3_count", out_count0, 16'd1);
        step(0, 32'd0, 0, 0, 1);

        // 4: overflow with 257 maximal products
        for (int i = 0; i < 257; i++) step(1, 32'hFFFE_0001, (i == 256), 0, 1);
        chk("t4_sum_sat", out_sum0, 40'hFF_FFFF_FFFF);
        chk("t4_ovf_sat", out_ovf0, 1'b1);
        chk("t4_sum_wrap", out_sum1, 40'h00_FDFE_0101);
        chk("t4_ovf_wrap", out_ovf1, 1'b1);
        chk("t4_count", out_count1, 16'd257);
        step(0, 32'd0, 0, 0, 1);

        // 5: clear together with a last beat
        step(1, 32'd5, 0, 0, 1);
        step(1, 32'd5, 0, 0, 1);
        step(1, 32'd9, 1, 1, 1);
        chk("t5_sum", out_sum0, 40'd9);
        chk("t5_count", out_count0, 16'd1);
        chk("t5_ovf", out_ovf0, 1'b0);
        step(0, 32'd0, 0, 0, 1);

        // zero product is a counted term
        step(1, 32'd0, 0, 0, 1);
        step(1, 32'd0, 1, 0, 1);
        chk("zero_count", out_count0, 16'd2);
        chk("zero_sum", out_sum0, 40'd0);
        step(0, 32'd0, 0, 0, 1);

        // 6: random traffic
        begin
            int beats = 0;
            int cyc = 0;
            while (beats < 10000 && cyc < 40000) begin
                bit v, l, c, o;
                logic [31:0] p;
                v = ($urandom_range(0, 3) != 0);
                l = ($urandom_range(0, 7) == 0);
                c = ($urandom_range(0, 31) == 0);
                o = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0: p = 32'd0;
                    1: p = 32'hFFFE_0001;
                    default: p = $urandom;
                endcase
                if (v && (!m_pend || o)) beats++;
                step(v, p, l, c, o);
                cyc++;
            end
            chk("rand_beats", beats, 10000);
        end

        // drain
        step(0, 32'd0, 0, 0, 1);
        step(0, 32'd0, 0, 0, 1);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        chk("drain_valid", out_valid0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
